rv32i_axi_master: RTL and testbench
===================================

RV32I_AXI_MASTER -- requirements
Module: rv32i_axi_master

Interface
REQ-001 The block SHALL have no parameters; address and data widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_instr  input  1  1 = instruction fetch; drives prot[2].
REQ-008 req_addr  input  32  byte address, passed to AXI unmodified.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_wstrb  input  4  byte enables.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  read data; 0 for writes.
REQ-013 resp_err  output  1  1 when the AXI response was SLVERR or DECERR (resp[1]=1).
REQ-014 m_axi_aw{addr[32],prot[3],valid} out, awready in; m_axi_w{data[32],strb[4],valid} out, wready in; m_axi_bresp[2], bvalid in, bready out; m_axi_ar{addr[32],prot[3],valid} out, arready in; m_axi_rdata[32], rresp[2], rvalid in, rready out.

Function
REQ-015 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; exactly one transaction outstanding at a time.
REQ-016 req_ready SHALL be 1 only in IDLE (combinational decode of state); all other outputs SHALL be registered.
REQ-017 On acceptance, the block SHALL latch addr, wdata, wstrb, and prot = {req_instr, 2'b00}; core inputs are ignored until the next IDLE.
REQ-018 Read: acceptance -> RD_ADDR with arvalid=1 on the next cycle; arvalid and araddr held stable until arvalid && arready.
REQ-019 AR handshake -> RD_DATA: arvalid=0, rready=1.
REQ-020 In RD_DATA, rvalid && rready SHALL cause, on the next cycle: resp_valid=1, resp_rdata=rdata, resp_err=rresp[1], rready=0, state=IDLE.
REQ-021 Write: acceptance -> WR_REQ with awvalid=1 and wvalid=1 on the same next cycle.
REQ-022 In WR_REQ, awvalid SHALL drop after its own handshake and wvalid after its own; each handshake is tracked independently, in either order or simultaneously.
REQ-023 When both handshakes are complete (including the same cycle), the block SHALL enter WR_RESP with bready=1.
REQ-024 In WR_RESP, bvalid && bready SHALL produce, on the next cycle: resp_valid=1, resp_rdata=0, resp_err=bresp[1], bready=0, state=IDLE.
REQ-025 resp_valid SHALL be high for exactly one cycle per accepted request, with no back-pressure from the core.
REQ-026 A new request MAY be accepted in the cycle resp_valid=1; minimum turnaround from acceptance to resp_valid is 3 cycles for both reads and writes against a zero-wait slave.
REQ-027 Writes with wstrb=4'b0000 SHALL still be issued on AXI unchanged.
REQ-028 No timeout: the FSM SHALL wait indefinitely for ready/valid from the slave.

Reset
REQ-029 While rst_n=0: state=IDLE; all AXI valid/ready outputs=0; resp_valid=0, resp_rdata=0, resp_err=0; latched address/data/strb/prot=0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no resp_valid generated for it.
REQ-031 After rst_n deasserts, req_ready SHALL be 1 on the first clock edge.

Verification
REQ-032 Read 0x0000_0004, memory slave latency 1, mem[1]=0x0000_0093 -> single arvalid handshake with araddr=0x4 and arprot=000; one resp_valid with rdata=0x0000_0093, err=0.
REQ-033 Fetch (req_instr=1) at 0x10 -> arprot=3'b100.
REQ-034 Write 0x8, data 0xAABB_CCDD, wstrb 4'b0011 -> a later read of 0x8 returns the prior upper half with low half 0xCCDD; resp_err=0 on both.
REQ-035 Slave awready two cycles before wready, then the reverse order, then both in the same cycle -> exactly one AW and one W handshake each time; one resp_valid each time.
REQ-036 RESP_LATENCY=5 with back-to-back read, write, read issued -> req_ready low throughout each transaction; three resp_valid pulses in request order with correct data.
REQ-037 Slave returns rresp=2'b10, then bresp=2'b11 -> resp_err=1 on each; rst_n pulsed during RD_DATA -> all valids 0 immediately, no resp_valid, next read completes normally.

Source files
------------

// File: rtl/rv32i_axi_master.sv
// Single-outstanding bridge from a simple core request port to an AXI4-Lite master.
// Each accepted request becomes one AXI read or write and finishes with a one-cycle resp_valid pulse.
module rv32i_axi_master (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_instr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,

    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // once raised, a valid and its payload stay stable until that transfer.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  prot_q;
    logic        aw_done;
    logic        w_done;

    assign req_ready     = (state == IDLE);
    assign dbg_state     = state;

    // Only one transaction is ever in flight, so both channels share one latched copy.
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = prot_q;
    assign m_axi_arprot  = prot_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;

    always_comb begin
        aw_done = !m_axi_awvalid || m_axi_awready;
        w_done  = !m_axi_wvalid  || m_axi_wready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            prot_q        <= 3'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        prot_q  <= {req_instr, 2'b00};
                        if (req_we) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= m_axi_rdata;
                        resp_err     <= m_axi_rresp[1];
                        state        <= IDLE;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; leave once neither is still pending.
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= 32'd0;
                        resp_err     <= m_axi_bresp[1];
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_axi_master.sv
// Directed bench for rv32i_axi_master with a small memory-backed AXI4-Lite slave
// whose ready delays, response latency and response codes are set per step.
module tb_rv32i_axi_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_instr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [2:0]  dbg_state;

    rv32i_axi_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_instr(req_instr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave configuration
    int          aw_delay, w_delay, ar_delay, resp_lat;
    logic [1:0]  rresp_cfg, bresp_cfg;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt;
    logic [31:0] mem [0:15];
    bit          mem_init;

    // Observations
    int          aw_hs, w_hs, ar_hs, ready_viol, spurious, lat, cyc, acc_cyc;
    bit          outstanding;
    logic [31:0] aw_rec, w_data_rec, ar_rec;
    logic [3:0]  w_strb_rec;
    logic [2:0]  ar_prot_rec;

    // Scoreboard: {err, rdata}
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    int          passed, total;

    initial begin
        cyc = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; ready_viol = 0; spurious = 0;
        lat = 0; acc_cyc = 0; outstanding = 0; mem_init = 0;
        aw_rec = 0; w_data_rec = 0; ar_rec = 0; w_strb_rec = 0; ar_prot_rec = 0;
    end

    // Slave drive: decides ready/valid on the falling edge from what the master shows
    always @(negedge clk) begin
        if (!rst_n) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_rvalid = 0; m_axi_bvalid = 0; m_axi_rdata = 0;
            m_axi_rresp = 0; m_axi_bresp = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0;
        end else begin
            if (m_axi_awvalid) begin
                if (aw_cnt >= aw_delay) m_axi_awready = 1;
                else begin m_axi_awready = 0; aw_cnt++; end
            end else begin m_axi_awready = 0; aw_cnt = 0; end
            if (m_axi_wvalid) begin
                if (w_cnt >= w_delay) m_axi_wready = 1;
                else begin m_axi_wready = 0; w_cnt++; end
            end else begin m_axi_wready = 0; w_cnt = 0; end
            if (m_axi_arvalid) begin
                if (ar_cnt >= ar_delay) m_axi_arready = 1;
                else begin m_axi_arready = 0; ar_cnt++; end
            end else begin m_axi_arready = 0; ar_cnt = 0; end
            if (m_axi_rready) begin
                if (r_cnt >= resp_lat) begin
                    m_axi_rvalid = 1; m_axi_rdata = mem[ar_rec[5:2]]; m_axi_rresp = rresp_cfg;
                end else begin m_axi_rvalid = 0; r_cnt++; end
            end else begin m_axi_rvalid = 0; r_cnt = 0; end
            if (m_axi_bready) begin
                if (b_cnt >= resp_lat) begin m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; end
                else begin m_axi_bvalid = 0; b_cnt++; end
            end else begin m_axi_bvalid = 0; b_cnt = 0; end
        end
    end

    // Monitor: samples pre-edge values on the rising edge
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] = 32'h0;
            mem[1] = 32'h0000_0093;
            mem[2] = 32'h1122_3344;
            mem[4] = 32'hDEAD_BEEF;
            mem_init = 1;
        end
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin aw_hs++; aw_rec = m_axi_awaddr; end
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs++; w_data_rec = m_axi_wdata; w_strb_rec = m_axi_wstrb;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs++; ar_rec = m_axi_araddr; ar_prot_rec = m_axi_arprot;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb_rec[b]) mem[aw_rec[5:2]][8*b +: 8] = w_data_rec[8*b +: 8];
            end
            if (outstanding && req_ready && !resp_valid) ready_viol++;
            if (resp_valid) begin
                if (!outstanding) spurious++;
                got_q.push_back({resp_err, resp_rdata});
                lat = cyc - acc_cyc;
                outstanding = 0;
            end
            if (req_valid && req_ready) begin outstanding = 1; acc_cyc = cyc; end
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Driver: present one request and return right after it is accepted
    task automatic issue(input logic we, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        int n;
        n = 0;
        @(negedge clk);
        req_we = we; req_instr = instr; req_addr = addr;
        req_wdata = wdata; req_wstrb = strb; req_valid = 1;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) chk("issue_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    // Wait for all expected responses, then compare them in order
    task automatic check_resps(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_resp"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    int aw0, w0, ar0;

    initial begin
        passed = 0; total = 0;
        rst_n = 0; req_valid = 0; req_we = 0; req_instr = 0;
        req_addr = 0; req_wdata = 0; req_wstrb = 0;
        aw_delay = 0; w_delay = 0; ar_delay = 0; resp_lat = 0;
        rresp_cfg = 0; bresp_cfg = 0;

        repeat (3) @(negedge clk);
        chk("rst_valids", 64'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
                               m_axi_rready, m_axi_bready, resp_valid}), 64'd0);
        chk("rst_resp", 64'({resp_err, resp_rdata}), 64'd0);
        chk("rst_latched", 64'({m_axi_araddr, m_axi_wstrb, m_axi_arprot}), 64'd0);
        chk("rst_wdata", 64'(m_axi_wdata), 64'd0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // Read 0x4 with latency 1
        resp_lat = 1; ar0 = ar_hs;
        exp_q.push_back({1'b0, 32'h0000_0093});
        issue(0, 0, 32'h4, 32'h0, 4'h0);
        check_resps("rd4");
        chk("rd4_ar_hs", 64'(ar_hs - ar0), 64'd1);
        chk("rd4_araddr", 64'(ar_rec), 64'h4);
        chk("rd4_arprot", 64'(ar_prot_rec), 64'd0);

        // Fetch 0x10, zero-wait: prot[2] set and 3-cycle turnaround
        resp_lat = 0;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        issue(0, 1, 32'h10, 32'h0, 4'h0);
        check_resps("fetch");
        chk("fetch_arprot", 64'(ar_prot_rec), 64'd4);
        chk("fetch_lat", 64'(lat), 64'd3);

        // Partial write then read back
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b0, 32'h1122_CCDD});
        issue(1, 0, 32'h8, 32'hAABB_CCDD, 4'b0011);
        issue(0, 0, 32'h8, 32'h0, 4'h0);
        check_resps("wr8");

        // AW before W, W before AW, then both together
        aw_delay = 0; w_delay = 2; aw0 = aw_hs; w0 = w_hs;
        exp_q.push_back({1'b0, 32'h0});
        issue(1, 0, 32'hC, 32'h0101_0101, 4'hF);
        check_resps("aw_first");
        chk("aw_first_hs", 64'({aw_hs - aw0, w_hs - w0}), {32'd1, 32'd1});
        aw_delay = 2; w_delay = 0; aw0 = aw_hs; w0 = w_hs;
        exp_q.push_back({1'b0, 32'h0});
        issue(1, 0, 32'hC, 32'h0202_0202, 4'hF);
        check_resps("w_first");
        chk("w_first_hs", 64'({aw_hs - aw0, w_hs - w0}), {32'd1, 32'd1});
        aw_delay = 0; w_delay = 0; aw0 = aw_hs; w0 = w_hs;
        exp_q.push_back({1'b0, 32'h0});
        issue(1, 0, 32'hC, 32'h0303_0303, 4'hF);
        check_resps("both");
        chk("both_hs", 64'({aw_hs - aw0, w_hs - w0}), {32'd1, 32'd1});
        chk("wr_lat", 64'(lat), 64'd3);

        // Zero-strobe write is still issued but changes nothing
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b0, 32'h1122_CCDD});
        issue(1, 0, 32'h8, 32'hFFFF_FFFF, 4'b0000);
        issue(0, 0, 32'h8, 32'h0, 4'h0);
        check_resps("strb0");
        chk("strb0_wstrb", 64'(w_strb_rec), 64'd0);
        chk("strb0_wdata", 64'(w_data_rec), 64'hFFFF_FFFF);

        // Back-to-back read, write, read with latency 5
        resp_lat = 5;
        exp_q.push_back({1'b0, 32'h0000_0093});
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b0, 32'h5566_7788});
        issue(0, 0, 32'h4, 32'h0, 4'h0);
        issue(1, 0, 32'hC, 32'h5566_7788, 4'hF);
        issue(0, 0, 32'hC, 32'h0, 4'h0);
        check_resps("b2b");
        chk("b2b_ready_busy", 64'(ready_viol), 64'd0);

        // Error responses
        resp_lat = 0; rresp_cfg = 2'b10;
        exp_q.push_back({1'b1, 32'h0000_0093});
        issue(0, 0, 32'h4, 32'h0, 4'h0);
        check_resps("rd_err");
        rresp_cfg = 2'b00; bresp_cfg = 2'b11;
        exp_q.push_back({1'b1, 32'h0});
        issue(1, 0, 32'h0, 32'h1, 4'hF);
        check_resps("wr_err");
        bresp_cfg = 2'b00;

        // Reset in RD_DATA abandons the read
        resp_lat = 10;
        issue(0, 0, 32'h4, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        chk("in_rd_data", 64'(m_axi_rready), 64'd1);
        rst_n = 0;
        #1;
        chk("midrst_valids", 64'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
                                  m_axi_rready, m_axi_bready, resp_valid}), 64'd0);
        chk("midrst_addr", 64'(m_axi_araddr), 64'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (15) @(negedge clk);
        chk("midrst_no_resp", 64'(got_q.size()), 64'd0);
        resp_lat = 0;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        issue(0, 0, 32'h10, 32'h0, 4'h0);
        check_resps("post_rst");
        chk("no_spurious", 64'(spurious), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=done", total);
        $fatal(1, "timeout");
    end

endmodule
